rle_stream_scheduler: RTL and testbench
=======================================

Name: rle_stream_scheduler

Overview:
Shares one rle_compressor instance between NUM_CH byte-stream requesters. Grants the compressor to one channel per packet, round-robin. Feeds the packet's bytes to the compressor, then runs a flush/clear sequence so the final run is emitted and the compressor is clean for the next packet. Each compressed token is tagged with its source channel and a last-of-packet flag. Sits between the per-channel packet sources and the rle_compressor datapath.

Parameters:
NUM_CH, 4, number of requester channels (2..16)
CH_W, $clog2(NUM_CH), width of channel index (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_CH  per-channel byte valid
req_ready  out  NUM_CH  per-channel byte accept; at most one bit high
req_data  in  NUM_CH*8  per-channel byte; channel i at [8i+7:8i]
req_last  in  NUM_CH  marks last byte of packet (qualified by valid&ready)
cmp_data_in  out  8  byte to compressor (registered)
cmp_valid_in  out  1  byte strobe to compressor (registered)
cmp_rst_n  out  1  compressor reset, active low (registered)
cmp_data_out  in  8  compressor run byte
cmp_count_out  in  8  compressor run length
cmp_valid_out  in  1  compressor run strobe
tok_valid  out  1  tagged token strobe (registered)
tok_data  out  8  run byte
tok_count  out  8  run length, 1..255
tok_ch  out  CH_W  source channel
tok_last  out  1  final token of packet
busy  out  1  high in any state but IDLE
pkt_done  out  16  completed-packet counter, wraps at 0xFFFF

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all outputs 0, including cmp_rst_n=0 (compressor held in reset), req_ready=0, pkt_done=0; rr pointer=NUM_CH-1, so ch0 has top priority first. cmp_rst_n returns to 1 at the first posedge with rst_n=1. Reset mid-packet drops the packet and any in-flight tokens; no tok_last is produced for it.
- Compressor latency is 1 cycle. tok_* are registered from cmp_*_out, adding 1 more cycle.
- IDLE: if any req_valid, grant the first set channel searching from rr+1 modulo NUM_CH. Set grant and rr=grant, go to STREAM. With no requests, stay in IDLE.
- STREAM: req_ready[grant]=1, all other ready bits 0.
  - On an accepted beat: cmp_valid_in<=1, cmp_data_in<=byte, shadow<=byte.
  - No beat: cmp_valid_in<=0. Gaps of any length are legal.
  - Accepted beat with req_last=1 (edge E0): go to FLUSH. req_ready drops the cycle after E0.
  - Packets are at least 1 byte long.
- FLUSH (1 cycle): cmp_valid_in<=1, cmp_data_in<=shadow^8'h01. This byte always differs from the last real byte, which forces emission of the final run. Next state DRAIN1.
- DRAIN1, DRAIN2: cmp_valid_in<=0, 1 cycle each.
- tok_valid<=cmp_valid_out only when the current state is STREAM, FLUSH, DRAIN1 or DRAIN2; otherwise 0. tok_last<=1 exactly for the capture in DRAIN2 (edge E3). tok_ch<=grant.
- CLEAR (1 cycle, entered at E3): cmp_rst_n<=0. This discards the dummy flush run. pkt_done+=1. Next state IDLE, cmp_rst_n<=1 at E4.
- Earliest next grant: IDLE evaluates in the cycle after E4, STREAM follows.
- Runs of 255 or more: the compressor splits them. Tokens (b,255) then the remainder pass through unmodified.
- A byte 0x00 as the first of a packet emits no spurious token, because the compressor resets last_byte to 0.
- req_valid on non-granted channels never changes state; the requester waits. Exactly one token per packet carries tok_last.

Test Plan:
- ch0 sends AA,AA,AA,BB(last) -> tokens (AA,3,ch0,last=0), (BB,1,ch0,last=1); pkt_done=1; busy low after CLEAR.
- ch1 sends 00,00(last) -> single token (00,2,ch1,last=1); no token with count 0 or byte 01.
- ch2 sends 300×55 with last on byte 300 -> (55,255,last=0), (55,45,last=1).
- ch0 and ch2 request together with 1-byte packets 11 and 22, ch0 re-requests immediately -> grant order ch0, ch2, ch0; tok_last token arrives 3 cycles after each last-beat acceptance.
- ch3 sends 7E,gap 5 cycles,7E,7E(last) -> (7E,3,ch3,last=1); req_ready held high through the gap.
- rst_n low for 1 cycle mid-packet on ch1 -> outputs 0, cmp_rst_n=0 during reset, no tok_last; a new ch1 packet 9C(last) -> (9C,1,last=1).

Source files
------------

// File: rtl/rle_stream_scheduler_if.sv
// Bundles the requester, compressor and token-side signals of the RLE stream scheduler.
// master = scheduler side, slave = surrounding sources, compressor and token sink.
interface rle_stream_scheduler_if #(
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_ready;
    logic [NUM_CH*8-1:0] req_data;
    logic [NUM_CH-1:0]   req_last;

    logic [7:0]          cmp_data_in;
    logic                cmp_valid_in;
    logic                cmp_rst_n;
    logic [7:0]          cmp_data_out;
    logic [7:0]          cmp_count_out;
    logic                cmp_valid_out;

    logic                tok_valid;
    logic [7:0]          tok_data;
    logic [7:0]          tok_count;
    logic [CH_W-1:0]     tok_ch;
    logic                tok_last;

    modport master (
        input  req_valid, req_data, req_last,
        input  cmp_data_out, cmp_count_out, cmp_valid_out,
        output req_ready,
        output cmp_data_in, cmp_valid_in, cmp_rst_n,
        output tok_valid, tok_data, tok_count, tok_ch, tok_last
    );

    modport slave (
        output req_valid, req_data, req_last,
        output cmp_data_out, cmp_count_out, cmp_valid_out,
        input  req_ready,
        input  cmp_data_in, cmp_valid_in, cmp_rst_n,
        input  tok_valid, tok_data, tok_count, tok_ch, tok_last
    );
endinterface

// File: rtl/rle_stream_scheduler.sv
// Round-robin scheduler sharing one rle_compressor among NUM_CH byte-stream requesters.
// Each packet is streamed, flushed with a differing byte, drained, then the compressor is cleared.
module rle_stream_scheduler #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rle_stream_scheduler_if.master        sched_if,
    output logic                          busy_o,
    output logic [15:0]                   pkt_done_o
);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [7:0]  FLUSH_XOR = 8'h01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        FLUSH  = 3'd2,
        DRAIN1 = 3'd3,
        DRAIN2 = 3'd4,
        CLEAR  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   pick;
    logic              found;
    int unsigned       idx;
    logic [7:0]        shadow_q, shadow_d;
    logic [7:0]        cmp_data_q, cmp_data_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic              cmp_rst_q, cmp_rst_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic              tok_valid_q, tok_valid_d;
    logic              tok_last_q, tok_last_d;
    logic [7:0]        tok_data_q, tok_count_q;
    logic [CH_W-1:0]   tok_ch_q;
    logic              busy_q, busy_d;
    logic [15:0]       pkt_q, pkt_d;
    logic [7:0]        beat_data;
    logic              beat_acc;
    logic              beat_last;
    logic              in_pkt;

    // Round-robin search starting one past the previous grant
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(rr_q) + k) % NUM_CH;
            if (!found && sched_if.req_valid[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    assign beat_data = sched_if.req_data[{grant_q, 3'b000} +: 8];
    assign beat_acc  = (state_q == STREAM) && sched_if.req_valid[grant_q] && ready_q[grant_q];
    assign beat_last = sched_if.req_last[grant_q];
    assign in_pkt    = state_q inside {STREAM, FLUSH, DRAIN1, DRAIN2};

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        shadow_d    = shadow_q;
        cmp_data_d  = cmp_data_q;
        cmp_valid_d = 1'b0;
        cmp_rst_d   = 1'b1;
        pkt_d       = pkt_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = pick;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat_acc) begin
                    cmp_valid_d = 1'b1;
                    cmp_data_d  = beat_data;
                    shadow_d    = beat_data;
                    if (beat_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // A byte guaranteed to differ from the last real one pushes out the final run
                cmp_valid_d = 1'b1;
                cmp_data_d  = shadow_q ^ FLUSH_XOR;
                state_d     = DRAIN1;
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                // Clearing the compressor discards the dummy flush run
                cmp_rst_d = 1'b0;
                pkt_d     = pkt_q + 16'd1;
                state_d   = CLEAR;
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d     = (state_d == STREAM) ? (NUM_CH'(1) << grant_d) : '0;
        busy_d      = (state_d != IDLE);
        tok_valid_d = in_pkt && sched_if.cmp_valid_out;
        tok_last_d  = (state_q == DRAIN2) && sched_if.cmp_valid_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= CH_W'(NUM_CH - 1);
            shadow_q    <= '0;
            cmp_data_q  <= '0;
            cmp_valid_q <= 1'b0;
            cmp_rst_q   <= 1'b0;
            ready_q     <= '0;
            tok_valid_q <= 1'b0;
            tok_last_q  <= 1'b0;
            tok_data_q  <= '0;
            tok_count_q <= '0;
            tok_ch_q    <= '0;
            busy_q      <= 1'b0;
            pkt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            shadow_q    <= shadow_d;
            cmp_data_q  <= cmp_data_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_rst_q   <= cmp_rst_d;
            ready_q     <= ready_d;
            tok_valid_q <= tok_valid_d;
            tok_last_q  <= tok_last_d;
            tok_data_q  <= sched_if.cmp_data_out;
            tok_count_q <= sched_if.cmp_count_out;
            tok_ch_q    <= grant_q;
            busy_q      <= busy_d;
            pkt_q       <= pkt_d;
        end
    end

    assign sched_if.req_ready    = ready_q;
    assign sched_if.cmp_data_in  = cmp_data_q;
    assign sched_if.cmp_valid_in = cmp_valid_q;
    assign sched_if.cmp_rst_n    = cmp_rst_q;
    assign sched_if.tok_valid    = tok_valid_q;
    assign sched_if.tok_data     = tok_data_q;
    assign sched_if.tok_count    = tok_count_q;
    assign sched_if.tok_ch       = tok_ch_q;
    assign sched_if.tok_last     = tok_last_q;
    assign busy_o                = busy_q;
    assign pkt_done_o            = pkt_q;
endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Bench for rle_stream_scheduler: per-channel packet drivers, a behavioural compressor,
// and a run-length reference model computed directly from each packet's bytes.
module tb_rle_stream_scheduler;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = $clog2(NUM_CH);

    typedef struct packed { logic idle; logic [7:0] d; logic last; } beat_t;
    typedef struct packed { logic [7:0] d; logic [7:0] c; logic [CH_W-1:0] ch; logic last; } tok_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] pkt_done;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          pkt_exp = 0;

    rle_stream_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    rle_stream_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sched_if   (bus),
        .busy_o     (busy),
        .pkt_done_o (pkt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural compressor: one-cycle latency, runs capped at 255, cleared by cmp_rst_n
    logic [7:0] c_last, c_cnt;
    always @(posedge clk) begin
        if (!bus.cmp_rst_n) begin
            c_last <= 8'h00; c_cnt <= 8'h00;
            bus.cmp_valid_out <= 1'b0; bus.cmp_data_out <= 8'h00; bus.cmp_count_out <= 8'h00;
        end else begin
            bus.cmp_valid_out <= 1'b0;
            if (bus.cmp_valid_in) begin
                if (bus.cmp_data_in == c_last && c_cnt != 8'd0 && c_cnt != 8'd255) begin
                    c_cnt <= c_cnt + 8'd1;
                end else begin
                    if (c_cnt != 8'd0) begin
                        bus.cmp_valid_out <= 1'b1;
                        bus.cmp_data_out  <= c_last;
                        bus.cmp_count_out <= c_cnt;
                    end
                    c_last <= bus.cmp_data_in;
                    c_cnt  <= 8'd1;
                end
            end
        end
    end

    tok_t  obs_q[$];
    int    obs_cyc[$];
    tok_t  exp_ch[NUM_CH][$];
    beat_t drv_q[NUM_CH][$];
    int    acc_cyc[$];
    logic [7:0] pkt_b[$];
    int    pkt_gap[$];

    initial forever begin
        @(negedge clk);
        if (bus.tok_valid === 1'b1) begin
            obs_q.push_back({bus.tok_data, bus.tok_count, bus.tok_ch, bus.tok_last});
            obs_cyc.push_back(cyc);
        end
    end

    // Per-channel driver: presents queue heads at negedge, pops a beat one cycle after it fires
    initial begin
        logic [NUM_CH-1:0]   v, l, fire;
        logic [NUM_CH*8-1:0] d;
        fire = '0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
        forever begin
            @(negedge clk);
            v = '0; l = '0; d = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (fire[ch] && drv_q[ch].size() > 0) void'(drv_q[ch].pop_front());
                if (drv_q[ch].size() > 0 && drv_q[ch][0].idle) begin
                    void'(drv_q[ch].pop_front());
                end else if (drv_q[ch].size() > 0) begin
                    v[ch] = 1'b1;
                    l[ch] = drv_q[ch][0].last;
                    d[ch*8 +: 8] = drv_q[ch][0].d;
                end
            end
            bus.req_valid = v; bus.req_last = l; bus.req_data = d;
            fire = v & bus.req_ready;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (fire[ch] && l[ch]) acc_cyc.push_back(cyc + 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    function automatic void add_byte(input logic [7:0] b, input int gap);
        pkt_b.push_back(b);
        pkt_gap.push_back(gap);
    endfunction

    // Queue the staged packet on a channel and derive its expected tokens from the bytes
    function automatic void push_pkt(input int ch);
        logic [7:0] cur;
        int n;
        for (int i = 0; i < pkt_b.size(); i++) begin
            for (int g = 0; g < pkt_gap[i]; g++) drv_q[ch].push_back({1'b1, 8'h00, 1'b0});
            drv_q[ch].push_back({1'b0, pkt_b[i], (i == pkt_b.size() - 1)});
        end
        cur = pkt_b[0];
        n = 0;
        foreach (pkt_b[i]) begin
            if (pkt_b[i] == cur && n < 255) n++;
            else begin
                exp_ch[ch].push_back({cur, 8'(n), CH_W'(ch), 1'b0});
                cur = pkt_b[i];
                n = 1;
            end
        end
        exp_ch[ch].push_back({cur, 8'(n), CH_W'(ch), 1'b1});
        pkt_exp++;
        pkt_b.delete();
        pkt_gap.delete();
    endfunction

    function automatic void clear_sb();
        obs_q.delete(); obs_cyc.delete(); acc_cyc.delete();
        for (int ch = 0; ch < NUM_CH; ch++) exp_ch[ch].delete();
    endfunction

    function automatic bit all_empty();
        for (int ch = 0; ch < NUM_CH; ch++) if (drv_q[ch].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (all_empty() && busy === 1'b0) quiet++; else quiet = 0;
            if (quiet >= 4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.cmp_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_cmp_rst_n: got %b want 0", bus.cmp_rst_n); end
        n_cmp++; if (bus.req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if ({bus.cmp_valid_in, bus.cmp_data_in} !== 9'd0) begin n_err++; $display("FAIL reset_cmp_in: got %b/%h want 0", bus.cmp_valid_in, bus.cmp_data_in); end
        n_cmp++; if ({bus.tok_valid, bus.tok_data, bus.tok_count, bus.tok_ch, bus.tok_last} !== '0) begin n_err++; $display("FAIL reset_tok: got v=%b d=%h c=%h", bus.tok_valid, bus.tok_data, bus.tok_count); end
        n_cmp++; if ({busy, pkt_done} !== 17'd0) begin n_err++; $display("FAIL reset_busy_cnt: got busy=%b pkt_done=%0d want 0/0", busy, pkt_done); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.cmp_rst_n !== 1'b1) begin n_err++; $display("FAIL reset_release: cmp_rst_n got %b want 1", bus.cmp_rst_n); end
    endtask

    task automatic test_runs();
        bit ok;
        int k;
        clear_sb();
        add_byte(8'hAA, 0); add_byte(8'hAA, 0); add_byte(8'hAA, 0); add_byte(8'hBB, 0);
        push_pkt(0);
        add_byte(8'h00, 0); add_byte(8'h00, 0);
        push_pkt(1);
        for (int i = 0; i < 300; i++) add_byte(8'h55, 0);
        push_pkt(2);
        wait_idle(1500, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL runs_idle: busy=%b after budget, want 0", busy); end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            k = 0;
            foreach (obs_q[i]) if (obs_q[i].ch == CH_W'(ch)) begin
                n_cmp++;
                if (k >= exp_ch[ch].size() || obs_q[i] !== exp_ch[ch][k]) begin
                    n_err++; $display("FAIL runs_tok ch%0d #%0d: got %h want %h", ch, k, obs_q[i], exp_ch[ch][k]);
                end
                k++;
            end
            n_cmp++; if (k != exp_ch[ch].size()) begin n_err++; $display("FAIL runs_ntok ch%0d: got %0d want %0d", ch, k, exp_ch[ch].size()); end
        end
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i].c == 8'd0 || obs_q[i].d == 8'h01) begin n_err++; $display("FAIL runs_spurious: got d=%h c=%0d", obs_q[i].d, obs_q[i].c); end
        end
        n_cmp++; if (pkt_done !== 16'(pkt_exp)) begin n_err++; $display("FAIL runs_pkt_done: got %0d want %0d", pkt_done, pkt_exp); end
    endtask

    task automatic test_gap();
        bit ok;
        int k;
        clear_sb();
        add_byte(8'h7E, 0); add_byte(8'h7E, 5); add_byte(8'h7E, 0);
        push_pkt(3);
        for (int i = 0; i < 50 && bus.req_ready[3] !== 1'b1; i++) begin @(negedge clk); #1; end
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL gap_grant: ready got %b want 1000", bus.req_ready); end
        for (int i = 0; i < 50 && drv_q[3].size() > 0; i++) begin
            @(negedge clk); #1;
            if (drv_q[3].size() > 0) begin
                n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL gap_ready cyc%0d: got %b want 1000", cyc, bus.req_ready); end
            end
        end
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL gap_idle: busy=%b after budget, want 0", busy); end
        k = 0;
        foreach (obs_q[i]) begin
            n_cmp++;
            if (k >= exp_ch[3].size() || obs_q[i] !== exp_ch[3][k]) begin n_err++; $display("FAIL gap_tok #%0d: got %h want %h", k, obs_q[i], exp_ch[3][k]); end
            k++;
        end
        n_cmp++; if (k != exp_ch[3].size()) begin n_err++; $display("FAIL gap_ntok: got %0d want %0d", k, exp_ch[3].size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int exp_order[3];
        exp_order = '{0, 2, 0};
        clear_sb();
        add_byte(8'h11, 0); push_pkt(0);
        add_byte(8'h33, 0); push_pkt(0);
        add_byte(8'h22, 0); push_pkt(2);
        wait_idle(300, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_idle: busy=%b after budget, want 0", busy); end
        n_cmp++; if (obs_q.size() != 3 || acc_cyc.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d tokens %0d lasts want 3/3", obs_q.size(), acc_cyc.size()); end
        for (int i = 0; i < 3 && i < obs_q.size() && i < acc_cyc.size(); i++) begin
            n_cmp++; if (obs_q[i].ch !== CH_W'(exp_order[i]) || obs_q[i].last !== 1'b1) begin n_err++; $display("FAIL b2b_order #%0d: got ch%0d last=%b want ch%0d last=1", i, obs_q[i].ch, obs_q[i].last, exp_order[i]); end
            n_cmp++; if (obs_cyc[i] - acc_cyc[i] != 3) begin n_err++; $display("FAIL b2b_latency #%0d: got %0d want 3", i, obs_cyc[i] - acc_cyc[i]); end
        end
        n_cmp++; if (obs_q.size() > 2 && (obs_q[0] !== exp_ch[0][0] || obs_q[1] !== exp_ch[2][0] || obs_q[2] !== exp_ch[0][1])) begin n_err++; $display("FAIL b2b_data: got %h %h %h", obs_q[0], obs_q[1], obs_q[2]); end
        n_cmp++; if (pkt_done !== 16'(pkt_exp)) begin n_err++; $display("FAIL b2b_pkt_done: got %0d want %0d", pkt_done, pkt_exp); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_last;
        clear_sb();
        for (int i = 0; i < 4; i++) drv_q[1].push_back({1'b0, (i < 2) ? 8'hA1 : 8'hA2, 1'b0});
        for (int i = 0; i < 100 && drv_q[1].size() != 0; i++) @(negedge clk);
        n_cmp++; if (drv_q[1].size() != 0) begin n_err++; $display("FAIL mid_accept: %0d beats left want 0", drv_q[1].size()); end
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.tok_valid, bus.cmp_valid_in, bus.cmp_rst_n, busy} !== 4'b0000) begin n_err++; $display("FAIL mid_reset_out: tok_v=%b cmp_v=%b cmp_rst_n=%b busy=%b want 0", bus.tok_valid, bus.cmp_valid_in, bus.cmp_rst_n, busy); end
        n_cmp++; if ({bus.req_ready, pkt_done} !== '0) begin n_err++; $display("FAIL mid_reset_state: ready=%b pkt_done=%0d want 0", bus.req_ready, pkt_done); end
        rst_n = 1'b1;
        pkt_exp = 0;
        repeat (6) @(negedge clk);
        n_last = 0;
        foreach (obs_q[i]) if (obs_q[i].last) n_last++;
        n_cmp++; if (n_last != 0) begin n_err++; $display("FAIL mid_no_last: got %0d last tokens want 0", n_last); end
        clear_sb();
        add_byte(8'h9C, 0); push_pkt(1);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_idle: busy=%b after budget, want 0", busy); end
        n_cmp++; if (obs_q.size() != 1 || obs_q[0] !== exp_ch[1][0]) begin n_err++; $display("FAIL mid_new_pkt: got %0d tokens first %h want 1 of %h", obs_q.size(), obs_q[0], exp_ch[1][0]); end
        n_cmp++; if (pkt_done !== 16'd1) begin n_err++; $display("FAIL mid_pkt_done: got %0d want 1", pkt_done); end
    endtask

    task automatic test_random();
        bit ok;
        int k, len, ch;
        logic [7:0] alpha[4];
        logic [7:0] rb;
        alpha = '{8'h00, 8'h01, 8'hA5, 8'hFE};
        clear_sb();
        for (int p = 0; p < 10; p++) begin
            ch  = int'($urandom_range(0, NUM_CH - 1));
            len = (p == 0) ? 250 + int'($urandom_range(0, 20)) : 1 + int'($urandom_range(0, 23));
            rb  = alpha[$urandom_range(0, 3)];
            for (int i = 0; i < len; i++) begin
                if (p != 0 && $urandom_range(0, 2) == 0) rb = alpha[$urandom_range(0, 3)];
                add_byte(rb, (i > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            push_pkt(ch);
        end
        wait_idle(4000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_idle: busy=%b after budget, want 0", busy); end
        for (int c = 0; c < NUM_CH; c++) begin
            k = 0;
            foreach (obs_q[i]) if (obs_q[i].ch == CH_W'(c)) begin
                n_cmp++;
                if (k >= exp_ch[c].size() || obs_q[i] !== exp_ch[c][k]) begin
                    n_err++; $display("FAIL rand_tok ch%0d #%0d: got %h want %h", c, k, obs_q[i], exp_ch[c][k]);
                end
                k++;
            end
            n_cmp++; if (k != exp_ch[c].size()) begin n_err++; $display("FAIL rand_ntok ch%0d: got %0d want %0d", c, k, exp_ch[c].size()); end
        end
        n_cmp++; if (pkt_done !== 16'(pkt_exp)) begin n_err++; $display("FAIL rand_pkt_done: got %0d want %0d", pkt_done, pkt_exp); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_runs();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
